// File: rtl/rb_pkg.sv
// rtl/rb_pkg.sv - shared types for the forwarding register bank
//
// Purpose : operand-source encodings used by reg_bank_fwd and rb_operand_mux.
// Contents: fwd_sel_t (2-bit operand source select)
//             FWD_RF  register-file value captured at the read edge
//             FWD_EX  live execute-stage result
//             FWD_DM  live data-memory-stage result
//             FWD_WB  live write-back-stage result
package rb_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_DM = 2'd2,
    FWD_WB = 2'd3
  } fwd_sel_t;

endpackage

// File: rtl/rb_operand_mux.sv
// rtl/rb_operand_mux.sv - per-read-port operand forwarding mux
//
// Purpose : picks one read port's operand from the captured register value
//           or one of the three live forwarding buses. Optionally lets an
//           immediate override the selection. Purely combinational.
// Params  : DATA_W  operand width
//           IMM_EN  1 = honour imm_sel/imm (used on the last port only)
// Ports   : rdq      in   DATA_W  value captured from the register file
//           fwd_sel  in   2       operand source (fwd_sel_t)
//           imm_sel  in   1       immediate override request
//           imm      in   DATA_W  immediate value
//           ans_ex   in   DATA_W  execute-stage result bus
//           ans_dm   in   DATA_W  data-memory-stage result bus
//           ans_wb   in   DATA_W  write-back-stage result bus
//           opnd     out  DATA_W  selected operand
module rb_operand_mux
  import rb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter bit IMM_EN = 1'b0
) (
  input  logic [DATA_W-1:0] rdq,
  input  fwd_sel_t          fwd_sel,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic [DATA_W-1:0] ans_wb,
  output logic [DATA_W-1:0] opnd
);

  always_comb begin
    opnd = rdq;
    case (fwd_sel)
      FWD_RF: opnd = rdq;
      FWD_EX: opnd = ans_ex;
      FWD_DM: opnd = ans_dm;
      FWD_WB: opnd = ans_wb;
      default: opnd = rdq;
    endcase
    // The immediate takes priority over any forwarding choice. On ports
    // without IMM_EN the condition folds to constant false.
    if (IMM_EN && imm_sel) begin
      opnd = imm;
    end
  end

endmodule

// File: rtl/reg_bank_fwd.sv
// rtl/reg_bank_fwd.sv - multi-port register bank with bypass, scoreboard and forwarding
//
// Purpose : decode-stage register file. It has 2**ADDR_W words of DATA_W bits,
//           NUM_RD registered read ports and one write port. Write-through
//           bypass makes a same-edge write visible to the reads captured at
//           that edge. A per-register pending bit flags read-after-write
//           hazards. Each port feeds an rb_operand_mux. The last port can also
//           take an immediate.
// Build   : RB_ZERO_REG_EN defined -> register 0 is hard-wired to zero. Writes
//           to it are dropped, it is never marked pending, and it is never
//           bypassed. Undefined -> register 0 is an ordinary register.
// Ports   : clk       in   1              rising-edge clock
//           rst_n     in   1              asynchronous active-low reset
//           rd_en     in   1              capture all read ports this edge
//           ra        in   NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
//           fwd_sel   in   NUM_RD*2       per-port operand source (rb_pkg::fwd_sel_t)
//           imm_sel   in   1              last port takes imm
//           imm       in   DATA_W         immediate value
//           ans_ex    in   DATA_W         execute-stage forwarding bus
//           ans_dm    in   DATA_W         data-memory-stage forwarding bus
//           ans_wb    in   DATA_W         write-back-stage forwarding bus
//           we        in   1              write enable
//           wa        in   ADDR_W         write address
//           wd        in   DATA_W         write data
//           iss_en    in   1              destination issued, mark iss_wa pending
//           iss_wa    in   ADDR_W         issued destination register
//           opnd      out  NUM_RD*DATA_W  operands, port p at [p*DATA_W +: DATA_W]
//           busy      out  NUM_RD         pending flag of each captured source
//           rd_valid  out  1              registered rd_en
module reg_bank_fwd
  import rb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  input  logic [NUM_RD*2-1:0]      fwd_sel,
  input  logic                     imm_sel,
  input  logic [DATA_W-1:0]        imm,
  input  logic [DATA_W-1:0]        ans_ex,
  input  logic [DATA_W-1:0]        ans_dm,
  input  logic [DATA_W-1:0]        ans_wb,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_wa,
  output logic [NUM_RD*DATA_W-1:0] opnd,
  output logic [NUM_RD-1:0]        busy,
  output logic                     rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pend_nxt;

  // Qualified write / issue strobes. With a hard-wired zero register, any
  // access to address 0 is squashed here. That one gate covers storage,
  // bypass and scoreboard together.
  logic wr_ok;
  logic iss_ok;

`ifdef RB_ZERO_REG_EN
  assign wr_ok  = we && (wa != '0);
  assign iss_ok = iss_en && (iss_wa != '0);
`else
  assign wr_ok  = we;
  assign iss_ok = iss_en;
`endif

  // Scoreboard next state. Set is applied after clear, so an issue and a
  // retiring write to the same register leave it pending. The newer
  // instruction now owns that register.
  always_comb begin
    pend_nxt = pending;
    if (wr_ok) begin
      pend_nxt[wa] = 1'b0;
    end
    if (iss_ok) begin
      pend_nxt[iss_wa] = 1'b1;
    end
  end

  // Storage and scoreboard. Asynchronous reset clears every word, so a write
  // or issue in flight when reset hits is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      pending <= '0;
    end else begin
      if (wr_ok) begin
        mem[wa] <= wd;
      end
      pending <= pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_W-1:0] ra_p;
    logic [DATA_W-1:0] rdq_p;
    logic              busy_q;
    logic              byp_hit;

    assign ra_p    = ra[p*ADDR_W +: ADDR_W];
    assign byp_hit = wr_ok && (wa == ra_p);

    // Capture register. The bypass returns the data being written this edge.
    // busy samples the scoreboard after this edge's set/clear, so a write to
    // the source clears it unless an issue re-marks the same register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdq_p  <= '0;
        busy_q <= 1'b0;
      end else if (rd_en) begin
        rdq_p  <= byp_hit ? wd : mem[ra_p];
        busy_q <= pend_nxt[ra_p];
      end
    end

    assign busy[p] = busy_q;

    rb_operand_mux #(
      .DATA_W (DATA_W),
      .IMM_EN (p == NUM_RD - 1)
    ) u_mux (
      .rdq     (rdq_p),
      .fwd_sel (fwd_sel_t'(fwd_sel[p*2 +: 2])),
      .imm_sel (imm_sel),
      .imm     (imm),
      .ans_ex  (ans_ex),
      .ans_dm  (ans_dm),
      .ans_wb  (ans_wb),
      .opnd    (opnd[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/reg_bank_fwd.md
# reg_bank_fwd

Parametrised multi-port register bank for the MIPS pipeline's decode stage. It replaces the fixed 32×16 two-read bank with these additions:
- configurable width, depth and read-port count;
- an explicit write enable;
- write-through bypass;
- a per-register pending scoreboard that flags read-after-write hazards.

Each read port has a forwarding mux (register file / EX / DM / WB result). The last read port also has an immediate override. Both feed the execute stage.

## Interface
Parameters:
- DATA_W, 16, register and bus width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (≥1); port NUM_RD-1 carries the immediate override

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_en  in  1  capture all read addresses this cycle
- ra  in  NUM_RD*ADDR_W  read addresses; port p = ra[p*ADDR_W +: ADDR_W]
- fwd_sel  in  NUM_RD*2  per-port operand source: 0 RF, 1 EX, 2 DM, 3 WB
- imm_sel  in  1  replace last port's operand with imm
- imm  in  DATA_W  immediate value
- ans_ex, ans_dm, ans_wb  in  DATA_W each  forwarding buses
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- iss_en  in  1  instruction with destination issued; mark iss_wa pending
- iss_wa  in  ADDR_W  issued destination register
- opnd  out  NUM_RD*DATA_W  operand outputs
- busy  out  NUM_RD  pending flag of each captured source
- rd_valid  out  1  registered copy of rd_en

## Operation
- Storage: 2**ADDR_W words of DATA_W bits. Writes occur on the rising clk edge when we=1.
- Read capture: on a clk edge with rd_en=1, each port latches mem[ra_p] into rdq_p and pending[ra_p] into busy_p. With rd_en=0, rdq and busy hold.
- Write-through: if we=1 and wa==ra_p on the capturing edge, rdq_p takes wd rather than the old contents. At the same edge busy_p takes 0, unless iss_en re-sets that address on the same edge (see below).
- Operand mux (combinational from rdq and the live buses): fwd_sel 0→rdq_p, 1→ans_ex, 2→ans_dm, 3→ans_wb.
- On the last port, imm_sel=1 overrides the mux with imm.
- Scoreboard: one pending bit per register.
  - iss_en sets pending[iss_wa].
  - we clears pending[wa].
  - If both target the same address on the same edge, set wins, because the newer instruction owns the register.
- Multiple ports may read the same address; all receive identical data.

## Timing
- Read latency: one cycle from ra/rd_en to rdq; opnd then follows fwd_sel/imm_sel combinationally in the same cycle.
- Write-to-read visible at the same edge (bypass). No stall cycle is required.
- busy reflects pending state as it is after updates at the capture edge.
- Reset (rst_n low, asynchronous):
  - all registers = 0, all pending = 0, rdq = 0, busy = 0, rd_valid = 0;
  - opnd therefore equals the mux of zeros and the live buses.
  - Reset asserted mid-operation discards in-flight writes and issue marks.
- Address wrap: none. Addresses are exact-width, so every value is valid.

## Configuration
- RB_ZERO_REG_EN defined:
  - register 0 always reads 0;
  - writes to address 0 are ignored;
  - pending[0] is never set;
  - the write-through bypass never returns wd for address 0.
- RB_ZERO_REG_EN undefined: register 0 is an ordinary register.

## Structure
- Package rb_pkg:
  - fwd_sel encodings FWD_RF, FWD_EX, FWD_DM, FWD_WB;
  - the 2-bit fwd_sel_t typedef.
- Sub-module rb_operand_mux: one instance per read port (generate loop), with a parameter enabling the imm override on the last port only.
- Storage, bypass and scoreboard live in the top module.

## Test plan
- Reset then read: pulse rst_n low, rd_en=1, ra={3,7}, fwd_sel=0 → opnd={0,0}, busy=0, rd_valid=1 after the edge.
- Write-through: we=1, wa=5, wd=16'hBEEF, rd_en=1, ra0=5 on the same edge → opnd0=16'hBEEF next cycle; with RB_ZERO_REG_EN, wa=0 and wd=16'h1234 → reads of 0 return 0.
- Forwarding: rdq0=16'h0011, ans_ex=16'h00AA, ans_dm=16'h00BB, ans_wb=16'h00CC; sweep fwd_sel0 0..3 → opnd0 = 0011, 00AA, 00BB, 00CC. Then imm_sel=1, imm=16'h7FFF → last port = 7FFF.
- Scoreboard: iss_en wa=9; next cycle read 9 → busy=1. we wa=9 later, then re-read → busy=0. iss_en and we both on 9 in the same cycle → pending stays 1.
- Async reset mid-stream: assert rst_n low between clk edges while pending[4]=1 and reg4=16'h5555 → busy and opnd drop to 0 immediately, and reg4 reads 0 after release.
- Parametrised build: DATA_W=32, ADDR_W=6, NUM_RD=3; write 32'hDEADBEEF to reg 63, read it on all three ports → identical values.
